// File: rtl/bip_debug_ctrl_pkg.sv
// bip_debug_ctrl_pkg: command bytes, ASCII framing characters and FSM states
// shared by the BIP debug controller and its bench.
// No ports; import with bip_debug_ctrl_pkg::*.
package bip_debug_ctrl_pkg;

  // Single-byte UART commands
  localparam logic [7:0] CMD_RUN  = 8'h72;  // 'r'
  localparam logic [7:0] CMD_STEP = 8'h73;  // 's'
  localparam logic [7:0] CMD_DUMP = 8'h64;  // 'd'
  localparam logic [7:0] CMD_CLR  = 8'h63;  // 'c'

  // Dump framing characters
  localparam logic [7:0] SP = 8'h20;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    STEP = 3'd2,
    LOAD = 3'd3,
    SEND = 3'd4,
    WAIT = 3'd5
  } state_t;

endpackage

// File: rtl/bip_debug_ctrl_if.sv
// bip_debug_ctrl_if: byte-wide UART receive/transmit strobes between the debug
// controller (master) and the UART rx/tx pair (slave).
// Signals: rx_done_tick/rx_data (received byte), tx_start/tx_data (byte to send),
// tx_done_tick (transmitter finished the current byte).
interface bip_debug_ctrl_if;

  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       tx_done_tick;
  logic       tx_start;
  logic [7:0] tx_data;

  modport master (
    input  rx_done_tick,
    input  rx_data,
    input  tx_done_tick,
    output tx_start,
    output tx_data
  );

  modport slave (
    output rx_done_tick,
    output rx_data,
    output tx_done_tick,
    input  tx_start,
    input  tx_data
  );

endinterface

// File: rtl/bip_debug_ctrl_nibble_to_ascii.sv
// nibble_to_ascii: 4-bit value to uppercase hex ASCII character.
// Latency: combinational. Backpressure: none.
// Ports: nibble (in, 4) -> ascii (out, 8): 0-9 -> 0x30-0x39, A-F -> 0x41-0x46.
module nibble_to_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) begin
      ascii = 8'h30 + {4'h0, nibble};
    end else begin
      // 0x37 + 10 = 0x41 ('A')
      ascii = 8'h37 + {4'h0, nibble};
    end
  end

endmodule

// File: rtl/bip_debug_ctrl.sv
// bip_debug_ctrl: UART command sequencer for the BIP core (run/step/clear/dump).
// Latency: 'd' seen at edge T -> first tx_start in cycle T+2; 's' and pre-halted 'r' -> T+3.
// Backpressure: one byte in flight, next byte only after tx_done_tick; rx bytes
//   arriving while busy are dropped, never queued.
// Ports: clk, reset (async, active-high); uart (master modport: rx/tx strobes);
//   halt, acc, pc, cycle_cnt from the core; bip_enable, bip_clr to the core; busy.
module bip_debug_ctrl
  import bip_debug_ctrl_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int N_WORDS = 3
) (
  input  logic                clk,
  input  logic                reset,
  bip_debug_ctrl_if.master    uart,
  input  logic                halt,
  input  logic [DATA_W-1:0]   acc,
  input  logic [DATA_W-1:0]   pc,
  input  logic [DATA_W-1:0]   cycle_cnt,
  output logic                bip_enable,
  output logic                bip_clr,
  output logic                busy
);

  localparam int DIGITS = DATA_W / 4;
  localparam int POS_W  = $clog2(DIGITS + 1);
  localparam int WRD_W  = $clog2(N_WORDS + 1);

  state_t            state;
  logic [DATA_W-1:0] snap [N_WORDS];
  logic [DATA_W-1:0] cap  [N_WORDS];

  // The byte index is kept as (word, position-in-word) so the decode needs no
  // division: pos 0..DIGITS-1 are hex digits, pos DIGITS is the separator
  // (space, or CR after the last word); word == N_WORDS is the trailing LF.
  logic [WRD_W-1:0]  word;
  logic [POS_W-1:0]  pos;

  logic [DATA_W-1:0] word_sel;
  logic [DATA_W-1:0] word_shift;
  logic [3:0]        nib;
  logic [7:0]        hex_char;
  logic [7:0]        cur_byte;
  logic              last_byte;
  logic              sep_pos;
  logic              last_word;

  // Word list in transmit order: acc, pc, cycle_cnt; extra words read as zero.
  always_comb begin
    for (int i = 0; i < N_WORDS; i++) begin
      cap[i] = '0;
      if (i == 0) begin
        cap[i] = acc;
      end else if (i == 1) begin
        cap[i] = pc;
      end else if (i == 2) begin
        cap[i] = cycle_cnt;
      end
    end
  end

  always_comb begin
    word_sel = '0;
    for (int i = 0; i < N_WORDS; i++) begin
      if (int'(word) == i) begin
        word_sel = snap[i];
      end
    end
  end

  // MS nibble first: shift the selected digit up to the top of the word.
  assign word_shift = word_sel << {pos, 2'b00};
  assign nib        = word_shift[DATA_W-1 -: 4];

  nibble_to_ascii u_hex (
    .nibble (nib),
    .ascii  (hex_char)
  );

  assign last_byte = (int'(word) == N_WORDS);
  assign sep_pos   = (int'(pos) == DIGITS);
  assign last_word = (int'(word) == N_WORDS - 1);

  always_comb begin
    cur_byte = hex_char;
    if (last_byte) begin
      cur_byte = LF;
    end else if (sep_pos) begin
      cur_byte = last_word ? CR : SP;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      uart.tx_start <= 1'b0;
      uart.tx_data  <= 8'h00;
      bip_enable    <= 1'b0;
      bip_clr       <= 1'b0;
      busy          <= 1'b0;
      word          <= '0;
      pos           <= '0;
      for (int i = 0; i < N_WORDS; i++) begin
        snap[i] <= '0;
      end
    end else begin
      uart.tx_start <= 1'b0;
      bip_clr       <= 1'b0;
      case (state)
        IDLE: begin
          if (uart.rx_done_tick) begin
            case (uart.rx_data)
              CMD_RUN: begin
                state      <= RUN;
                // Already halted: skip straight through RUN without enabling.
                bip_enable <= ~halt;
                busy       <= 1'b1;
              end
              CMD_STEP: begin
                state      <= STEP;
                bip_enable <= 1'b1;
                busy       <= 1'b1;
              end
              CMD_DUMP: begin
                state <= LOAD;
                busy  <= 1'b1;
              end
              CMD_CLR: begin
                bip_clr <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          if (halt) begin
            bip_enable <= 1'b0;
            state      <= LOAD;
          end else begin
            bip_enable <= 1'b1;
          end
        end
        STEP: begin
          bip_enable <= 1'b0;
          state      <= LOAD;
        end
        LOAD: begin
          for (int i = 0; i < N_WORDS; i++) begin
            snap[i] <= cap[i];
          end
          word  <= '0;
          pos   <= '0;
          state <= SEND;
        end
        SEND: begin
          uart.tx_data  <= cur_byte;
          uart.tx_start <= 1'b1;
          state         <= WAIT;
        end
        WAIT: begin
          if (uart.tx_done_tick) begin
            if (last_byte) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              if (sep_pos) begin
                pos  <= '0;
                word <= word + WRD_W'(1);
              end else begin
                pos <= pos + POS_W'(1);
              end
              state <= SEND;
            end
          end
        end
        default: begin
          state      <= IDLE;
          bip_enable <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bip_debug_ctrl.sv
// tb_bip_debug_ctrl: bench for bip_debug_ctrl with a UART transmitter stub,
// a core cycle counter driven by bip_enable/bip_clr, and a text-level dump model.
module tb_bip_debug_ctrl;
  import bip_debug_ctrl_pkg::*;

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] acc;
    logic [15:0] pc;
    int          preset;     // core cycle count loaded before the command, -1 = keep
    bit          pre_halt;
    int          run_len;    // cycles until halt rises for 'r'
    int          exp_bytes;
    int          exp_en;
    int          exp_clr;
    int          exp_lat;    // cycles from command edge to first tx_start, 0 = none
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        halt;
  logic [15:0] acc;
  logic [15:0] pc;
  logic [15:0] core_cnt;
  logic        bip_enable;
  logic        bip_clr;
  logic        busy;

  bip_debug_ctrl_if u ();

  bip_debug_ctrl #(.DATA_W(16), .N_WORDS(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .uart       (u),
    .halt       (halt),
    .acc        (acc),
    .pc         (pc),
    .cycle_cnt  (core_cnt),
    .bip_enable (bip_enable),
    .bip_clr    (bip_clr),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_starts = 0;
  int          en_cnt = 0;
  int          clr_cnt = 0;
  int          dbl_start = 0;
  int          unstable = 0;
  int          start_cyc[$];
  string       got = "";
  logic        prev_start = 1'b0;
  int          preset_seq = 0;
  int          preset_done = 0;
  logic [15:0] preset_val = '0;
  logic [15:0] model_cnt = '0;
  vec_t        tbl[10];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor plus a behavioural core: cycle_cnt counts enabled cycles.
  initial begin
    core_cnt = '0;
    forever begin
      @(negedge clk);
      if (u.tx_start) begin
        n_starts++;
        got = $sformatf("%s%c", got, u.tx_data);
        start_cyc.push_back(cyc);
      end
      if (u.tx_start && prev_start) dbl_start++;
      prev_start = u.tx_start;
      if (bip_enable) en_cnt++;
      if (bip_clr) clr_cnt++;
      if (bip_clr) core_cnt = '0;
      else if (bip_enable) core_cnt = core_cnt + 16'd1;
      if (preset_seq != preset_done) begin
        core_cnt    = preset_val;
        preset_done = preset_seq;
      end
    end
  end

  // UART transmitter stub: accepts a byte on tx_start, finishes 1-4 cycles later.
  initial begin
    logic [7:0] cur;
    u.tx_done_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (u.tx_start) begin
        cur = u.tx_data;
        repeat ($urandom_range(1, 4)) begin
          @(negedge clk);
          if (busy && u.tx_data !== cur) unstable++;
        end
        u.tx_done_tick = 1'b1;
        @(negedge clk);
        u.tx_done_tick = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded its time budget after %0d checks", n_vec);
    $fatal(1);
  end

  function automatic string hex_word(input logic [15:0] v);
    string digits = "0123456789ABCDEF";
    string s = "";
    int    d;
    for (int i = 3; i >= 0; i--) begin
      d = int'((v >> (4 * i)) & 16'hF);
      s = {s, digits.substr(d, d)};
    end
    return s;
  endfunction

  function automatic string dump_text(input logic [15:0] a, input logic [15:0] p,
                                      input logic [15:0] c);
    return {hex_word(a), " ", hex_word(p), " ", hex_word(c), "\015\012"};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_text(input string name, input string g, input string e);
    int diff;
    n_vec++;
    if (g != e) begin
      diff = -1;
      for (int i = 0; i < e.len() && i < g.len(); i++) begin
        if (diff < 0 && g[i] != e[i]) diff = i;
      end
      n_err++;
      $display("FAIL %s: got %0d bytes, expected %0d bytes, first differing byte %0d",
               name, g.len(), e.len(), diff);
    end
  endtask

  task automatic send_cmd(input logic [7:0] b, output int t_edge);
    @(negedge clk);
    u.rx_data      = b;
    u.rx_done_tick = 1'b1;
    t_edge         = cyc + 1;
    @(negedge clk);
    u.rx_done_tick = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_idle"}, int'(busy), 0);
  endtask

  task automatic set_core_cnt(input logic [15:0] v);
    preset_val = v;
    preset_seq++;
    @(negedge clk);
    @(negedge clk);
    model_cnt = v;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int    b_st, b_len, b_en, b_clr, t;
    string e, g;
    acc = v.acc;
    pc  = v.pc;
    if (v.preset >= 0) set_core_cnt(16'(v.preset));
    halt = v.pre_halt;
    @(posedge clk);
    #1;
    b_st = n_starts; b_len = got.len(); b_en = en_cnt; b_clr = clr_cnt;
    send_cmd(v.cmd, t);
    if (v.cmd == CMD_RUN && !v.pre_halt) begin
      repeat (v.run_len - 1) @(negedge clk);
      halt = 1'b1;
    end
    wait_idle(name);
    repeat (6) @(negedge clk);
    halt = 1'b0;
    case (v.cmd)
      CMD_STEP: model_cnt = model_cnt + 16'd1;
      CMD_RUN:  if (!v.pre_halt) model_cnt = model_cnt + 16'(v.run_len);
      CMD_CLR:  model_cnt = '0;
      default: ;
    endcase
    e = (v.exp_bytes > 0) ? dump_text(v.acc, v.pc, model_cnt) : "";
    g = (got.len() > b_len) ? got.substr(b_len, got.len() - 1) : "";
    chk({name, "_bytes"}, n_starts - b_st, v.exp_bytes);
    chk_text({name, "_text"}, g, e);
    chk({name, "_enable_cycles"}, en_cnt - b_en, v.exp_en);
    chk({name, "_clr_cycles"}, clr_cnt - b_clr, v.exp_clr);
    if (v.exp_lat > 0) begin
      if (start_cyc.size() > b_st) chk({name, "_latency"}, start_cyc[b_st] - t, v.exp_lat);
      else chk({name, "_latency"}, -1, v.exp_lat);
    end
  endtask

  initial begin
    int    t, b_st, b_len, b_clr, b_en, k;
    string g;
    vec_t  v;

    reset = 1'b1; halt = 1'b0; acc = '0; pc = '0;
    u.rx_done_tick = 1'b0; u.rx_data = 8'h00;

    //         cmd      acc       pc        preset    ph run bytes en clr lat
    tbl[0] = '{CMD_DUMP, 16'h00AB, 16'h0012, 'h0100,   0, 0,  16,  0,  0,  2};
    tbl[1] = '{8'h78,    16'h1111, 16'h2222, -1,       0, 0,  0,   0,  0,  0};
    tbl[2] = '{CMD_CLR,  16'h1111, 16'h2222, -1,       0, 0,  0,   0,  1,  0};
    tbl[3] = '{CMD_STEP, 16'h1234, 16'h0013, -1,       0, 0,  16,  1,  0,  3};
    tbl[4] = '{CMD_RUN,  16'h7FFF, 16'h00FF, -1,       0, 37, 16,  37, 0,  39};
    tbl[5] = '{CMD_RUN,  16'h0001, 16'h0002, -1,       1, 0,  16,  0,  0,  3};
    tbl[6] = '{CMD_DUMP, 16'hFFFF, 16'hA5C3, 'hFFFF,   0, 0,  16,  0,  0,  2};
    tbl[7] = '{CMD_STEP, 16'h0000, 16'h0000, -1,       0, 0,  16,  1,  0,  3};
    tbl[8] = '{CMD_CLR,  16'h0000, 16'h0000, -1,       0, 0,  0,   0,  1,  0};
    tbl[9] = '{CMD_DUMP, 16'h9A0F, 16'h8000, -1,       0, 0,  16,  0,  0,  2};

    #12;
    chk("reset_tx_start",   int'(u.tx_start), 0);
    chk("reset_tx_data",    int'(u.tx_data),  0);
    chk("reset_bip_enable", int'(bip_enable), 0);
    chk("reset_bip_clr",    int'(bip_clr),    0);
    chk("reset_busy",       int'(busy),       0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_vec(tbl[i], $sformatf("tbl%0d", i));
    end

    // Commands arriving during a dump are dropped.
    acc = 16'h0BAD; pc = 16'h0042;
    @(posedge clk);
    #1;
    b_st = n_starts; b_len = got.len(); b_clr = clr_cnt; b_en = en_cnt;
    send_cmd(CMD_DUMP, t);
    k = 0;
    while ((n_starts - b_st) < 3 && k < 500) begin
      @(negedge clk);
      #1;
      k++;
    end
    send_cmd(CMD_CLR, t);
    repeat (3) @(negedge clk);
    send_cmd(CMD_DUMP, t);
    wait_idle("busy_drop");
    repeat (30) @(negedge clk);
    g = (got.len() > b_len) ? got.substr(b_len, got.len() - 1) : "";
    chk("busy_drop_bytes", n_starts - b_st, 16);
    chk_text("busy_drop_text", g, dump_text(16'h0BAD, 16'h0042, model_cnt));
    chk("busy_drop_clr", clr_cnt - b_clr, 0);
    chk("busy_drop_enable", en_cnt - b_en, 0);

    // Reset in the middle of a dump, right after the fifth byte starts.
    acc = 16'hC0DE; pc = 16'h0777;
    @(posedge clk);
    #1;
    b_st = n_starts;
    send_cmd(CMD_DUMP, t);
    k = 0;
    while ((n_starts - b_st) < 5 && k < 500) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("rst_reached_byte5", n_starts - b_st, 5);
    reset = 1'b1;
    #1;
    chk("rst_tx_start",   int'(u.tx_start), 0);
    chk("rst_tx_data",    int'(u.tx_data),  0);
    chk("rst_busy",       int'(busy),       0);
    chk("rst_bip_enable", int'(bip_enable), 0);
    chk("rst_bip_clr",    int'(bip_clr),    0);
    b_st = n_starts;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    chk("rst_no_stray_start", n_starts - b_st, 0);
    chk("rst_idle_busy", int'(busy), 0);
    v = '{CMD_DUMP, 16'hC0DE, 16'h0777, -1, 0, 0, 16, 0, 0, 2};
    run_vec(v, "after_reset");

    // Randomised commands checked against the text-level model.
    for (int i = 0; i < 12; i++) begin
      int sel;
      sel = $urandom_range(0, 4);
      case (sel)
        0: v.cmd = CMD_RUN;
        1: v.cmd = CMD_STEP;
        2: v.cmd = CMD_DUMP;
        3: v.cmd = CMD_CLR;
        default: begin
          v.cmd = 8'($urandom_range(0, 255));
          if (v.cmd inside {CMD_RUN, CMD_STEP, CMD_DUMP, CMD_CLR}) v.cmd = 8'h00;
        end
      endcase
      v.acc       = 16'($urandom);
      v.pc        = 16'($urandom);
      v.preset    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : -1;
      v.pre_halt  = (v.cmd == CMD_RUN) && ($urandom_range(0, 1) == 1);
      v.run_len   = $urandom_range(1, 20);
      v.exp_bytes = (v.cmd inside {CMD_RUN, CMD_STEP, CMD_DUMP}) ? 16 : 0;
      v.exp_en    = (v.cmd == CMD_STEP) ? 1 :
                    (v.cmd == CMD_RUN && !v.pre_halt) ? v.run_len : 0;
      v.exp_clr   = (v.cmd == CMD_CLR) ? 1 : 0;
      v.exp_lat   = (v.cmd == CMD_DUMP) ? 2 :
                    (v.cmd == CMD_STEP) ? 3 :
                    (v.cmd == CMD_RUN)  ? (v.pre_halt ? 3 : v.run_len + 2) : 0;
      run_vec(v, $sformatf("rnd%0d", i));
    end

    chk("tx_start_single_cycle", dbl_start, 0);
    chk("tx_data_stable_in_wait", unstable, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
